// File: rtl/alu_sequencer.sv
// alu_sequencer: command-driven controller for an external 8-bit ALU.
// Holds the accumulator and carry flag. Each accepted command runs as zero
// or more ALU cycles: single ops, multi-bit shifts, and a shift-add multiply.
module alu_sequencer #(
    parameter int         MUL_STEPS = 8,
    parameter logic [7:0] ACC_RST   = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd,
    input  logic [7:0] operand,
    output logic       done,
    output logic [7:0] acc,
    output logic       carry,
    output logic       busy,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_opr,
    input  logic [7:0] alu_r,
    input  logic       alu_co
);

    typedef enum logic { IDLE, EXEC } state_t;
    typedef enum logic [1:0] { K_SINGLE, K_SHIFT, K_MUL } kind_t;

    localparam logic [2:0] OPR_PASS = 3'b000;
    localparam logic [2:0] OPR_ADD  = 3'b010;
    localparam logic [2:0] OPR_SHL  = 3'b101;
    localparam logic [3:0] LAST_STEP = 4'(MUL_STEPS - 1);

    state_t     state_q, state_d;
    kind_t      kind_q, kind_d;
    logic [2:0] opr_q, opr_d;      // latched ALU op for single/shift commands
    logic [7:0] opnd_q, opnd_d;    // latched B operand
    logic [2:0] cnt_q, cnt_d;      // remaining shift cycles
    logic [7:0] p_q, p_d;          // multiply partial product
    logic [7:0] m_q, m_d;          // multiplicand, shifted left each step
    logic [7:0] q_q, q_d;          // multiplier, shifted right each step
    logic [3:0] step_q, step_d;    // multiply step index
    logic       phase_q, phase_d;  // 0 = ADD phase, 1 = SHIFT phase
    logic [7:0] acc_q, acc_d;
    logic       carry_q, carry_d;
    logic       done_q, done_d;

    // Next-state, ALU drive and handshake decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d   = state_q;
        kind_d    = kind_q;
        opr_d     = opr_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        m_d       = m_q;
        q_d       = q_q;
        step_d    = step_q;
        phase_d   = phase_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        done_d    = 1'b0;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        alu_a     = acc_q;
        alu_b     = 8'h00;
        alu_opr   = OPR_PASS;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (!cmd[3]) begin
                        opr_d  = cmd[2:0];
                        opnd_d = operand;
                        if (cmd[2:1] == 2'b10) begin
                            // Shift by zero completes without touching the ALU.
                            if (operand[2:0] == 3'd0) begin
                                carry_d = 1'b0;
                                done_d  = 1'b1;
                            end else begin
                                kind_d  = K_SHIFT;
                                cnt_d   = operand[2:0];
                                state_d = EXEC;
                            end
                        end else begin
                            kind_d  = K_SINGLE;
                            state_d = EXEC;
                        end
                    end else if (cmd == 4'd8) begin
                        kind_d  = K_MUL;
                        p_d     = 8'h00;
                        m_d     = acc_q;
                        q_d     = operand;
                        step_d  = 4'd0;
                        phase_d = 1'b0;
                        state_d = EXEC;
                    end else begin
                        done_d = 1'b1;  // NOP
                    end
                end
            end

            EXEC: begin
                busy = 1'b1;
                case (kind_q)
                    K_SINGLE: begin
                        alu_b   = opnd_q;
                        alu_opr = opr_q;
                        acc_d   = alu_r;
                        carry_d = (opr_q == 3'b001 || opr_q == 3'b010) ? alu_co : 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                    K_SHIFT: begin
                        alu_opr = opr_q;
                        acc_d   = alu_r;
                        carry_d = 1'b0;
                        cnt_d   = cnt_q - 3'd1;
                        if (cnt_q == 3'd1) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    default: begin
                        if (!phase_q) begin
                            alu_a   = p_q;
                            alu_b   = q_q[0] ? m_q : 8'h00;
                            alu_opr = OPR_ADD;
                            p_d     = alu_r;
                            phase_d = 1'b1;
                        end else begin
                            alu_a   = m_q;
                            alu_opr = OPR_SHL;
                            m_d     = alu_r;
                            q_d     = q_q >> 1;
                            phase_d = 1'b0;
                            step_d  = step_q + 4'd1;
                            if (step_q == LAST_STEP) begin
                                // P already holds the final sum from the preceding ADD phase.
                                acc_d   = p_q;
                                carry_d = 1'b0;
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end
                        end
                    end
                endcase
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any command in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            kind_q  <= K_SINGLE;
            opr_q   <= 3'd0;
            opnd_q  <= 8'h00;
            cnt_q   <= 3'd0;
            p_q     <= 8'h00;
            m_q     <= 8'h00;
            q_q     <= 8'h00;
            step_q  <= 4'd0;
            phase_q <= 1'b0;
            acc_q   <= ACC_RST;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update together from pre-edge values.
            state_q <= state_d;
            kind_q  <= kind_d;
            opr_q   <= opr_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            m_q     <= m_d;
            q_q     <= q_d;
            step_q  <= step_d;
            phase_q <= phase_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            done_q  <= done_d;
        end
    end

    assign acc   = acc_q;
    assign carry = carry_q;
    assign done  = done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer with a behavioural ALU beside it.
module tb_alu_sequencer;

    logic       clock;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd;
    logic [7:0] operand;
    logic       done;
    logic [7:0] acc;
    logic       carry;
    logic       busy;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_opr;
    logic [7:0] alu_r;
    logic       alu_co;

    int checks   = 0;
    int failures = 0;

    alu_sequencer #(.MUL_STEPS(8), .ACC_RST(8'h00)) dut (
        .clock    (clock),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd      (cmd),
        .operand  (operand),
        .done     (done),
        .acc      (acc),
        .carry    (carry),
        .busy     (busy),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_opr  (alu_opr),
        .alu_r    (alu_r),
        .alu_co   (alu_co)
    );

    // Behavioural 8-bit ALU.
    always_comb begin
        alu_co = 1'b0;
        case (alu_opr)
            3'b000: alu_r = alu_b;
            3'b001: begin alu_r = alu_a - alu_b; alu_co = (alu_a < alu_b); end
            3'b010: {alu_co, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
            3'b011: alu_r = alu_a ^ alu_b;
            3'b100: alu_r = {alu_a[7], alu_a[7:1]};
            3'b101: alu_r = {alu_a[6:0], 1'b0};
            3'b110: alu_r = alu_a & alu_b;
            default: alu_r = alu_a | alu_b;
        endcase
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Issue one command from IDLE; cyc = cycle (accept edge closes cycle 0) in which done is seen, -1 on timeout.
    task automatic run_cmd(input logic [3:0] c, input logic [7:0] o, input int max_cyc,
                           output int cyc, output int busy_cnt);
        cmd       = c;
        operand   = o;
        cmd_valid = 1'b1;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        cmd       = 4'h2;   // scramble inputs after acceptance
        operand   = 8'hAA;
        cyc       = 1;
        busy_cnt  = 0;
        while (done !== 1'b1 && cyc <= max_cyc) begin
            if (busy === 1'b1) busy_cnt++;
            @(posedge clock); #1;
            cyc++;
        end
        if (done !== 1'b1) cyc = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd = 4'h0; operand = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (acc !== 8'h00 || carry !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: acc=%h carry=%b ready=%b busy=%b done=%b, want 00 0 1 0 0",
                     acc, carry, cmd_ready, busy, done);
        end
        checks++;
        if (alu_opr !== 3'b000 || alu_a !== 8'h00 || alu_b !== 8'h00) begin
            failures++;
            $display("FAIL reset_alu: opr=%b a=%h b=%h, want 000 00 00", alu_opr, alu_a, alu_b);
        end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_load_add();
        int cyc, bc;
        run_cmd(4'd0, 8'd200, 10, cyc, bc);
        checks++;
        if (cyc !== 2 || acc !== 8'd200) begin
            failures++;
            $display("FAIL load200: cyc=%0d acc=%0d, want 2 200", cyc, acc);
        end
        run_cmd(4'd2, 8'd100, 10, cyc, bc);
        checks++;
        if (cyc !== 2 || acc !== 8'd44 || carry !== 1'b1) begin
            failures++;
            $display("FAIL add100: cyc=%0d acc=%0d carry=%b, want 2 44 1", cyc, acc, carry);
        end
        // ALU drive in the done (IDLE) cycle
        checks++;
        if (alu_opr !== 3'b000 || alu_a !== 8'd44 || alu_b !== 8'h00) begin
            failures++;
            $display("FAIL idle_alu: opr=%b a=%h b=%h, want 000 2c 00", alu_opr, alu_a, alu_b);
        end
        run_cmd(4'd12, 8'h55, 10, cyc, bc);
        checks++;
        if (cyc !== 1 || acc !== 8'd44 || carry !== 1'b1 || bc !== 0) begin
            failures++;
            $display("FAIL nop: cyc=%0d acc=%0d carry=%b busy=%0d, want 1 44 1 0", cyc, acc, carry, bc);
        end
        @(posedge clock); #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_width: done=%b one cycle after pulse, want 0", done);
        end
    endtask

    task automatic test_sub_and();
        int cyc, bc;
        run_cmd(4'd0, 8'd5, 10, cyc, bc);
        run_cmd(4'd1, 8'd7, 10, cyc, bc);
        checks++;
        if (cyc !== 2 || acc !== 8'd254 || carry !== 1'b1) begin
            failures++;
            $display("FAIL sub7: cyc=%0d acc=%0d carry=%b, want 2 254 1", cyc, acc, carry);
        end
        run_cmd(4'd6, 8'h0F, 10, cyc, bc);
        checks++;
        if (acc !== 8'h0E || carry !== 1'b0) begin
            failures++;
            $display("FAIL and0f: acc=%h carry=%b, want 0e 0", acc, carry);
        end
        run_cmd(4'd3, 8'hFF, 10, cyc, bc);
        checks++;
        if (acc !== 8'hF1 || carry !== 1'b0) begin
            failures++;
            $display("FAIL xorff: acc=%h carry=%b, want f1 0", acc, carry);
        end
        run_cmd(4'd7, 8'h08, 10, cyc, bc);
        checks++;
        if (acc !== 8'hF9) begin
            failures++;
            $display("FAIL or08: acc=%h, want f9", acc);
        end
    endtask

    task automatic test_shift();
        int cyc, bc;
        run_cmd(4'd0, 8'h80, 10, cyc, bc);
        run_cmd(4'd4, 8'd3, 10, cyc, bc);
        checks++;
        if (cyc !== 4 || bc !== 3 || acc !== 8'hF0 || carry !== 1'b0) begin
            failures++;
            $display("FAIL sra3: cyc=%0d busy=%0d acc=%h carry=%b, want 4 3 f0 0", cyc, bc, acc, carry);
        end
        run_cmd(4'd5, 8'd0, 10, cyc, bc);
        checks++;
        if (cyc !== 1 || bc !== 0 || acc !== 8'hF0) begin
            failures++;
            $display("FAIL shl0: cyc=%0d busy=%0d acc=%h, want 1 0 f0", cyc, bc, acc);
        end
        // Only operand[2:0] counts: 0x0A shifts by 2.
        run_cmd(4'd5, 8'h0A, 10, cyc, bc);
        checks++;
        if (cyc !== 3 || acc !== 8'hC0) begin
            failures++;
            $display("FAIL shl2: cyc=%0d acc=%h, want 3 c0", cyc, acc);
        end
    endtask

    task automatic test_mul();
        int cyc, bc;
        run_cmd(4'd0, 8'd13, 10, cyc, bc);
        run_cmd(4'd8, 8'd11, 40, cyc, bc);
        checks++;
        if (cyc !== 17 || bc !== 16 || acc !== 8'd143 || carry !== 1'b0) begin
            failures++;
            $display("FAIL mul13x11: cyc=%0d busy=%0d acc=%0d carry=%b, want 17 16 143 0", cyc, bc, acc, carry);
        end
        // 2 - 238 leaves acc=20 with borrow set; MUL must clear it.
        run_cmd(4'd0, 8'd2, 10, cyc, bc);
        run_cmd(4'd1, 8'd238, 10, cyc, bc);
        run_cmd(4'd8, 8'd15, 40, cyc, bc);
        checks++;
        if (cyc !== 17 || acc !== 8'd44 || carry !== 1'b0) begin
            failures++;
            $display("FAIL mul20x15: cyc=%0d acc=%0d carry=%b, want 17 44 0", cyc, acc, carry);
        end
    endtask

    task automatic test_ignore_during_exec();
        int cyc, bc;
        int ready_seen;
        run_cmd(4'd0, 8'd13, 10, cyc, bc);
        cmd = 4'd8; operand = 8'd11; cmd_valid = 1'b1;
        @(posedge clock); #1;
        cmd = 4'd2; operand = 8'd1;  // keep valid asserted with an ADD
        cyc = 1; ready_seen = 0;
        while (done !== 1'b1 && cyc <= 40) begin
            if (cmd_ready !== 1'b0) ready_seen++;
            @(posedge clock); #1;
            cyc++;
        end
        cmd_valid = 1'b0;
        checks++;
        if (ready_seen !== 0) begin
            failures++;
            $display("FAIL ready_in_exec: cmd_ready high in %0d exec cycles, want 0", ready_seen);
        end
        checks++;
        if (cyc !== 17 || acc !== 8'd143) begin
            failures++;
            $display("FAIL mul_ignore: cyc=%0d acc=%0d, want 17 143", cyc, acc);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        run_cmd(4'd0, 8'd3, 10, cyc, bc);
        checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready: ready=%b done=%b in done cycle, want 1 1", cmd_ready, done);
        end
        run_cmd(4'd2, 8'd4, 10, cyc, bc);
        checks++;
        if (cyc !== 2 || acc !== 8'd7) begin
            failures++;
            $display("FAIL b2b_add: cyc=%0d acc=%0d, want 2 7", cyc, acc);
        end
        run_cmd(4'd9, 8'd0, 10, cyc, bc);
        checks++;
        if (cyc !== 1 || acc !== 8'd7) begin
            failures++;
            $display("FAIL b2b_nop: cyc=%0d acc=%0d, want 1 7", cyc, acc);
        end
    endtask

    task automatic test_reset_mid_mul();
        int cyc, bc;
        int done_seen;
        run_cmd(4'd0, 8'd13, 10, cyc, bc);
        cmd = 4'd8; operand = 8'd11; cmd_valid = 1'b1;
        @(posedge clock); #1;       // now in exec cycle 1
        cmd_valid = 1'b0;
        repeat (6) begin @(posedge clock); #1; end  // exec cycle 7
        reset = 1'b1;
        #1;
        checks++;
        if (acc !== 8'h00 || carry !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_mul: acc=%h carry=%b busy=%b ready=%b done=%b, want 00 0 0 1 0",
                     acc, carry, busy, cmd_ready, done);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        done_seen = 0;
        repeat (20) begin
            @(posedge clock); #1;
            if (done === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen !== 0 || acc !== 8'h00) begin
            failures++;
            $display("FAIL abort_no_done: done pulses=%0d acc=%h, want 0 00", done_seen, acc);
        end
    endtask

    initial begin
        test_reset();
        test_load_add();
        test_sub_and();
        test_shift();
        test_mul();
        test_ignore_during_exec();
        test_back_to_back();
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command-driven controller that owns the 8-bit ALU (ops: 000 pass B, 001 A-B, 010 A+B, 011 XOR, 100 arithmetic shift right by 1, 101 shift left by 1, 110 AND, 111 OR; Co valid only for 001/010, else 0).
- Holds an accumulator (ACC) and carry flag (C). Accepts one command at a time over a valid/ready handshake.
- Executes the command as one or more ALU cycles: single ops, multi-bit shifts, and an 8x8 shift-add multiply.
- The ALU is instantiated beside this block. The sequencer drives its A/B/OPR and samples R/Co in the same cycle.

Parameters:
- MUL_STEPS, 8, number of multiplier bits processed by MUL (1..8); each step costs 2 exec cycles.
- ACC_RST, 8'h00, ACC value after reset.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd  in  4  0-7 = ALU op applied to ACC; 8 = MUL; 9-15 = NOP.
- operand  in  8  B operand, shift count (bits 2:0), or multiplier.
- done  out  1  one-cycle pulse: command completed.
- acc  out  8  accumulator.
- carry  out  1  carry/borrow flag C.
- busy  out  1  high in EXEC.
- alu_a  out  8  to ALU A.
- alu_b  out  8  to ALU B.
- alu_opr  out  3  to ALU OPR.
- alu_r  in  8  from ALU R, combinational.
- alu_co  in  1  from ALU Co, combinational.

Behaviour:
- Reset values: acc=ACC_RST, carry=0, done=0, busy=0, cmd_ready=1, state IDLE, alu_opr=000, alu_a=ACC_RST, alu_b=0.
- Reset asserted mid-command aborts it: no done pulse, ACC/C forced to reset values.
- States:
  - IDLE: cmd_ready=1. Handshake is cmd_valid&cmd_ready at an edge; it latches cmd/operand and goes to EXEC, or stays in IDLE with done pulsed next cycle if the command needs 0 exec cycles.
  - EXEC: cmd_ready=0, busy=1, cmd_valid ignored. Returns to IDLE after the last exec cycle.
- done is high in the first IDLE cycle after completion. A new command may be accepted in that same cycle.
- In IDLE the ALU outputs are alu_opr=000, alu_a=acc, alu_b=0.
- Every exec cycle drives the ALU and registers alu_r/alu_co at the closing edge.
- cmd 0,1,2,3,6,7:
  - One exec cycle: alu_a=ACC, alu_b=operand, alu_opr=cmd[2:0]; ACC<=alu_r.
  - C<=alu_co for cmd 1/2, else C<=0.
  - Accept at edge of cycle 0 -> exec cycle 1 -> done and new acc in cycle 2.
- cmd 4/5 (SRA/SHL):
  - n=operand[2:0] exec cycles, each alu_a=ACC, alu_opr=cmd[2:0]; C<=0.
  - n=0: no exec cycles, ACC unchanged, C<=0, done in cycle 1.
  - Internal 3-bit down-counter; terminates at 0, no wrap.
- cmd 8 (MUL):
  - Init: P=0, M=ACC, Q=operand.
  - Each step has an ADD phase then a SHIFT phase.
  - ADD phase: alu_a=P, alu_b=(Q[0]?M:0), opr=010; P<=alu_r; Co ignored.
  - SHIFT phase: alu_a=M, opr=101; M<=alu_r; Q<=Q>>1.
  - Exactly 2*MUL_STEPS exec cycles regardless of data.
  - Result: ACC<=P (product mod 256), C<=0, done in cycle 2*MUL_STEPS+1.
- cmd 9-15: no exec cycle, ACC and C unchanged, done in cycle 1.
- Arithmetic is modulo 256. Borrow on SUB is ALU Co (1 when A<B).
- cmd/operand changes after acceptance have no effect.

Test Plan:
- Reset -> acc=0x00, carry=0, cmd_ready=1. LOAD 200 (cmd 0), then ADD 100 (cmd 2) -> acc=44, carry=1; done exactly 2 cycles after each accept.
- LOAD 5, SUB 7 -> acc=254, carry=1. Then AND 0x0F -> acc=0x0E, carry=0.
- LOAD 0x80, SRA operand=3 -> busy for 3 cycles, done at cycle 4, acc=0xF0. SHL operand=0 -> done at cycle 1, acc unchanged.
- LOAD 13, MUL 11 -> acc=143 after 16 exec cycles, done at cycle 17. LOAD 20, MUL 15 -> acc=44, carry=0.
- Assert cmd_valid with cmd 2 throughout a MUL -> ignored, cmd_ready=0. Back-to-back accept in the done cycle -> second command executes, no lost or duplicated done.
- Assert reset at exec cycle 7 of a MUL -> immediate acc=ACC_RST, carry=0, busy=0, cmd_ready=1, no done pulse.
